// File: rtl/addsub_pkg.sv
// addsub_pkg -- shared definitions for the serial add/subtract block.
//   state_t : FSM encoding (IDLE=0, RUN=1, DONE=2), 2 bits.
//   cnt_w() : width of the slice counter, clog2(N+1) for N slice steps.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// addsub_slice -- STEP-bit combinational ripple-carry slice.
//   a_bits, b_bits : slice operands (b already inverted for subtract)
//   cin            : carry into bit 0 of the slice
//   s_bits         : slice sum
//   cout           : carry out of the slice MSB
//   c_msb_in       : carry into the slice MSB (for signed overflow)
module addsub_slice #(
  parameter int STEP = 1
) (
  input  logic [STEP-1:0] a_bits,
  input  logic [STEP-1:0] b_bits,
  input  logic            cin,
  output logic [STEP-1:0] s_bits,
  output logic            cout,
  output logic            c_msb_in
);

  logic [STEP:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < STEP; i++) begin : g_bit
    assign s_bits[i] = a_bits[i] ^ b_bits[i] ^ c[i];
    assign c[i+1]    = (a_bits[i] & b_bits[i]) | (c[i] & (a_bits[i] ^ b_bits[i]));
  end

  assign cout     = c[STEP];
  assign c_msb_in = c[STEP-1];

endmodule

// File: rtl/addsub_serial.sv
// addsub_serial -- bit-serial two's-complement adder/subtractor.
// Processes STEP bits per cycle LSB-first, WIDTH/STEP cycles per operation,
// with a valid/ready handshake on both operand and result sides.
//   clk, rst_n              : clock (rising edge), async active-low reset
//   start_valid/start_ready : operand handshake (a, b, sub sampled on accept)
//   a, b, sub               : operands; sub=1 computes a-b
//   res_valid/res_ready     : result handshake
//   sum, cout, ovf          : result, raw carry out of MSB, signed overflow
// Optional build macro ADDSUB_SAT_EN: saturate sum on signed overflow.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = cnt_w(N);

  if (WIDTH < 2 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_cfg
    $error("addsub_serial: WIDTH must be >= 2 and a multiple of STEP");
  end

  state_t          state;
  logic [WIDTH-1:0] a_sh;   // a operand shifting out low, result shifting in high
  logic [WIDTH-1:0] b_sh;   // effective b (inverted for sub)
  logic            carry;
  logic [CW-1:0]   count;

  logic [STEP-1:0]  s_bits;
  logic             s_cout;
  logic             s_cmsb;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] sum_fin;
  logic             ovf_next;
  logic             last;

  addsub_slice #(.STEP(STEP)) u_slice (
    .a_bits   (a_sh[STEP-1:0]),
    .b_bits   (b_sh[STEP-1:0]),
    .cin      (carry),
    .s_bits   (s_bits),
    .cout     (s_cout),
    .c_msb_in (s_cmsb)
  );

  // Sum bits enter at the top of a_sh as operand bits leave the bottom, so
  // after N steps a_sh holds the complete result.
  if (STEP == WIDTH) begin : g_one_step
    assign res_next = s_bits;
  end else begin : g_multi_step
    assign res_next = {s_bits, a_sh[WIDTH-1:STEP]};
  end

  // Only meaningful on the last step, when the slice holds the operand MSBs.
  assign ovf_next = s_cout ^ s_cmsb;
  assign last     = (count == CW'(N - 1));

`ifdef ADDSUB_SAT_EN
  // On overflow both effective signs agree; positive overflow clamps to max.
  always_comb begin
    sum_fin = res_next;
    if (ovf_next) begin
      if (!a_sh[STEP-1] && !b_sh[STEP-1])
        sum_fin = {1'b0, {(WIDTH-1){1'b1}}};
      else
        sum_fin = {1'b1, {(WIDTH-1){1'b0}}};
    end
  end
`else
  assign sum_fin = res_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      carry       <= 1'b0;
      count       <= '0;
      sum         <= '0;
      cout        <= 1'b0;
      ovf         <= 1'b0;
      res_valid   <= 1'b0;
      start_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid && start_ready) begin
            // sub only steers the operand inversion and carry-in, so it
            // needs no register of its own.
            a_sh        <= a;
            b_sh        <= b ^ {WIDTH{sub}};
            carry       <= sub;
            count       <= '0;
            start_ready <= 1'b0;
            state       <= RUN;
          end
        end
        RUN: begin
          a_sh  <= res_next;
          b_sh  <= b_sh >> STEP;
          carry <= s_cout;
          count <= count + 1'b1;
          if (last) begin
            sum       <= sum_fin;
            cout      <= s_cout;
            ovf       <= ovf_next;
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid   <= 1'b0;
            start_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          res_valid   <= 1'b0;
          start_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial -- directed checks for addsub_serial (STEP=1 and STEP=4).
module tb_addsub_serial;

`ifdef ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start_valid, start_ready, sub, res_valid, res_ready, cout, ovf;
  logic [7:0] a, b, sum;

  logic       start_valid4, start_ready4, sub4, res_valid4, res_ready4, cout4, ovf4;
  logic [7:0] a4, b4, sum4;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  addsub_serial #(.WIDTH(8), .STEP(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b), .sub(sub),
    .res_valid(res_valid), .res_ready(res_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  addsub_serial #(.WIDTH(8), .STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid4), .start_ready(start_ready4),
    .a(a4), .b(b4), .sub(sub4),
    .res_valid(res_valid4), .res_ready(res_ready4),
    .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One STEP=1 operation: accept, latency check, result check, optional
  // result stall with junk on the operand side, then handshake.
  task automatic do_op(input string tag, input logic [7:0] a_i, input logic [7:0] b_i,
                       input logic s_i, input logic [7:0] es, input logic ec,
                       input logic eo, input int stall);
    chk({tag, ".ready_in"}, start_ready, 1'b1);
    start_valid = 1'b1; a = a_i; b = b_i; sub = s_i;
    @(posedge clk); #1;
    start_valid = 1'b0;
    // operand changes after the accept edge must not matter
    a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
    chk({tag, ".busy"}, start_ready, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    chk({tag, ".early"}, res_valid, 1'b0);
    @(posedge clk); #1;
    chk({tag, ".valid"}, res_valid, 1'b1);
    chk({tag, ".sum"}, sum, es);
    chk({tag, ".cout"}, cout, ec);
    chk({tag, ".ovf"}, ovf, eo);
    if (stall > 0) begin
      start_valid = 1'b1; a = 8'hAA; b = 8'h55;
      repeat (stall) @(posedge clk);
      #1;
      chk({tag, ".stall_valid"}, res_valid, 1'b1);
      chk({tag, ".stall_sum"}, sum, es);
      chk({tag, ".stall_flags"}, {cout, ovf}, {ec, eo});
      chk({tag, ".stall_ready"}, start_ready, 1'b0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    start_valid = 1'b0;
    chk({tag, ".idle_valid"}, res_valid, 1'b0);
    chk({tag, ".idle_ready"}, start_ready, 1'b1);
    chk({tag, ".hold_sum"}, sum, es);
  endtask

  initial begin
    start_valid = 1'b0; res_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    start_valid4 = 1'b0; res_ready4 = 1'b0; a4 = '0; b4 = '0; sub4 = 1'b0;

    #12;
    chk("rst.ready", start_ready, 1'b1);
    chk("rst.valid", res_valid, 1'b0);
    chk("rst.out", {sum, cout, ovf}, 10'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("add5p3",  8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 0);
    do_op("sub3m5",  8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 0);
    do_op("sub5m3",  8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0, 0);
    do_op("ovf_add", 8'h7F, 8'h01, 1'b0, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1, 0);
    do_op("ovf_sub", 8'h80, 8'h01, 1'b1, SAT ? 8'h80 : 8'h7F, 1'b1, 1'b1, 0);
    do_op("stall",   8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 5);

    // reset in the middle of an operation
    start_valid = 1'b1; a = 8'h55; b = 8'h11; sub = 1'b0;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst.ready", start_ready, 1'b1);
    chk("mid_rst.valid", res_valid, 1'b0);
    chk("mid_rst.out", {sum, cout, ovf}, 10'h0);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_rst.no_result", res_valid, 1'b0);
    do_op("post_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 0);

    // STEP=4: two cycles per operation
    start_valid4 = 1'b1; a4 = 8'hFF; b4 = 8'h01; sub4 = 1'b0;
    @(posedge clk); #1;
    start_valid4 = 1'b0;
    @(posedge clk); #1;
    chk("s4.early", res_valid4, 1'b0);
    @(posedge clk); #1;
    chk("s4.valid", res_valid4, 1'b1);
    chk("s4.sum", sum4, 8'h00);
    chk("s4.flags", {cout4, ovf4}, 2'b10);
    res_ready4 = 1'b1;
    @(posedge clk); #1;
    res_ready4 = 1'b0;
    chk("s4.idle", {res_valid4, start_ready4}, 2'b01);

    start_valid4 = 1'b1; a4 = 8'h80; b4 = 8'h01; sub4 = 1'b1;
    @(posedge clk); #1;
    start_valid4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("s4sub.valid", res_valid4, 1'b1);
    chk("s4sub.sum", sum4, SAT ? 8'h80 : 8'h7F);
    chk("s4sub.flags", {cout4, ovf4}, 2'b11);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/addsub_serial.md
ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits, >= 2.
REQ-002 SHALL have parameter STEP, default 1: bits processed per cycle; WIDTH % STEP == 0 enforced at elaboration.
REQ-003 SHALL have clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have start_valid  input  1  operands present.
REQ-006 SHALL have start_ready  output  1  block can accept operands.
REQ-007 SHALL have a  input  WIDTH  first operand, two's complement.
REQ-008 SHALL have b  input  WIDTH  second operand, two's complement.
REQ-009 SHALL have sub  input  1  0 = a+b, 1 = a-b.
REQ-010 SHALL have res_valid  output  1  result present.
REQ-011 SHALL have res_ready  input  1  consumer accepts result.
REQ-012 SHALL have sum  output  WIDTH  result.
REQ-013 SHALL have cout  output  1  raw carry out of MSB (sub: 1 = no borrow).
REQ-014 SHALL have ovf  output  1  signed overflow.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; N = WIDTH/STEP.
REQ-016 IDLE: start_ready=1; on start_valid&&start_ready latch a, b^{WIDTH{sub}}, sub, carry<=sub, count<=0, go RUN.
REQ-017 RUN: each cycle add STEP bits LSB-first with registered carry, shift into result register, count++; after N cycles go DONE.
REQ-018 Latency: operand accepted at edge k, res_valid=1 after edge k+N.
REQ-019 DONE: res_valid=1; sum/cout/ovf stable until res_valid&&res_ready, then IDLE on that edge.
REQ-020 start_ready SHALL be 0 in RUN and DONE; a, b, sub changes outside the accept edge SHALL be ignored.
REQ-021 ovf SHALL equal carry into MSB XOR carry out of MSB; cout = carry out of MSB.
REQ-022 sum, cout, ovf SHALL be 0 in IDLE/RUN until the first result; thereafter hold last result until next DONE.
REQ-023 No back-to-back overlap: next accept earliest on the edge after result handshake (one IDLE cycle).

Reset
REQ-024 rst_n low SHALL immediately force IDLE, count=0, carry=0, sum=0, cout=0, ovf=0, res_valid=0, start_ready=1.
REQ-025 Reset during RUN or DONE SHALL discard the operation; no result is produced.

Configuration
REQ-026 Macro ADDSUB_SAT_EN defined: when ovf=1, sum SHALL be 0111..1 if the effective operand signs are both 0, else 1000..0; ovf still reported.
REQ-027 ADDSUB_SAT_EN undefined: sum SHALL be the wrap-around WIDTH-bit result.

Structure
REQ-028 Package addsub_pkg SHALL hold the state encoding (IDLE=0, RUN=1, DONE=2, 2 bits) and the count-width function clog2(N+1).
REQ-029 Sub-module addsub_slice SHALL be the STEP-bit combinational ripple slice (a_bits, b_bits, cin -> s_bits, cout, c_msb_in); instantiated once.

Verification (WIDTH=8, STEP=1 unless noted)
REQ-030 0x05+0x03, sub=0 -> sum=0x08, cout=0, ovf=0, res_valid exactly 8 cycles after accept.
REQ-031 0x03-0x05, sub=1 -> sum=0xFE, cout=0, ovf=0; 0x05-0x03 -> 0x02, cout=1.
REQ-032 0x7F+0x01 -> ovf=1, sum=0x80 (no macro) / 0x7F (ADDSUB_SAT_EN); 0x80-0x01 -> ovf=1, sum=0x7F / 0x80.
REQ-033 res_ready held low 5 cycles in DONE -> sum/flags stable, start_ready=0, start_valid ignored; accept on handshake, IDLE next.
REQ-034 rst_n pulsed low at RUN cycle 4 -> all outputs 0, start_ready=1 asynchronously; fresh 0x10+0x20 -> 0x30 after 8 cycles.
REQ-035 STEP=4, WIDTH=8: 0xFF+0x01 -> sum=0x00, cout=1, ovf=0, latency 2 cycles.
